// File: rtl/sda_kernel_ctrl_pkg.sv
// Shared register map, bit positions and handshake state encoding for the
// SDA kernel control block.
package sda_kernel_ctrl_pkg;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_GIE    = 8'h04;
   localparam logic [7:0] ADDR_IER    = 8'h08;
   localparam logic [7:0] ADDR_ISR    = 8'h0C;
   localparam logic [7:0] ADDR_CYCLES = 8'h10;

   localparam int BIT_AP_START = 0;
   localparam int BIT_AP_DONE  = 1;
   localparam int BIT_AP_IDLE  = 2;
   localparam int BIT_GIE      = 0;
   localparam int BIT_IER_DONE = 0;
   localparam int BIT_ISR_DONE = 0;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_GO        = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_ACK       = 2'd3;

   localparam logic [31:0] CYCLES_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] ctrl_word(input logic start, input logic done, input logic idle);
      logic [31:0] w;
      w = '0;
      w[BIT_AP_START] = start;
      w[BIT_AP_DONE]  = done;
      w[BIT_AP_IDLE]  = idle;
      return w;
   endfunction

endpackage

// File: rtl/sda_kernel_handshake.sv
// go/done four-phase handshake with the downstream action plus a saturating
// run-length cycle counter.
module sda_kernel_handshake
   import sda_kernel_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ap_start,
   input  logic        go_0a,
   input  logic        done_0r,
   output logic        go_0r,
   output logic        done_0a,
   output logic        idle,
   output logic        complete,
   output logic [31:0] cycles
);

   logic [1:0]  state_reg, state_next;
   logic [31:0] cycles_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:      if (ap_start && !go_0a) state_next = ST_GO;
         ST_GO:        if (go_0a)              state_next = ST_WAIT_DONE;
         ST_WAIT_DONE: if (done_0r)            state_next = ST_ACK;
         ST_ACK:       if (!done_0r)           state_next = ST_IDLE;
         default:                              state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         cycles_reg <= '0;
      end else begin
         state_reg <= state_next;
         // Counter restarts on launch and counts every non-idle cycle
         if (state_reg == ST_IDLE) begin
            if (state_next == ST_GO) cycles_reg <= '0;
         end else if (cycles_reg != CYCLES_MAX) begin
            cycles_reg <= cycles_reg + 32'd1;
         end
      end
   end

   assign go_0r    = (state_reg == ST_GO);
   assign done_0a  = (state_reg == ST_ACK);
   assign idle     = (state_reg == ST_IDLE);
   assign complete = (state_reg == ST_ACK) && !done_0r;
   assign cycles   = cycles_reg;

endmodule

// File: rtl/sda_kernel_ctrl.sv
// AXI-lite control/status registers for one SDA action; the go/done handshake
// and cycle counter live in sda_kernel_handshake.
module sda_kernel_ctrl
   import sda_kernel_ctrl_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic              go_0r,
   input  logic              go_0a,
   input  logic              done_0r,
   output logic              done_0a,
   output logic              interrupt
);

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
   localparam logic [ADDR_W-1:0] A_GIE    = ADDR_W'(ADDR_GIE);
   localparam logic [ADDR_W-1:0] A_IER    = ADDR_W'(ADDR_IER);
   localparam logic [ADDR_W-1:0] A_ISR    = ADDR_W'(ADDR_ISR);
   localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(ADDR_CYCLES);

   logic [1:0]  rst_sync_reg;
   logic        rst_n;
   logic        awready_reg, bvalid_reg, arready_reg, rvalid_reg;
   logic [31:0] rdata_reg, rdata_next;
   logic        ap_start_reg, ap_done_reg, gie_reg, ier_reg, isr_reg;
   logic        wr_en, wr_b0, rd_en, wbit;
   logic        hs_idle, hs_complete;
   logic [31:0] hs_cycles;
   logic        unused_wbits;

   // Reset asserts immediately but releases two clocks later, in step with clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_reg <= 2'b00;
      else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_n = rst_sync_reg[1];

   assign wr_en = awready_reg && s_axi_awvalid && s_axi_wvalid;
   assign wr_b0 = wr_en && s_axi_wstrb[0];
   assign wbit  = s_axi_wdata[0];
   assign rd_en = arready_reg && s_axi_arvalid;
   assign unused_wbits = ^{s_axi_wdata[31:1], s_axi_wstrb[3:1]};

   always_comb begin
      rdata_next = '0;
      if (s_axi_araddr == A_CTRL)        rdata_next = ctrl_word(ap_start_reg, ap_done_reg, hs_idle);
      else if (s_axi_araddr == A_GIE)    rdata_next[BIT_GIE] = gie_reg;
      else if (s_axi_araddr == A_IER)    rdata_next[BIT_IER_DONE] = ier_reg;
      else if (s_axi_araddr == A_ISR)    rdata_next[BIT_ISR_DONE] = isr_reg;
      else if (s_axi_araddr == A_CYCLES) rdata_next = hs_cycles;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready_reg <= 1'b0;
         bvalid_reg  <= 1'b0;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         awready_reg <= s_axi_awvalid && s_axi_wvalid && !bvalid_reg && !awready_reg;
         if (wr_en)             bvalid_reg <= 1'b1;
         else if (s_axi_bready) bvalid_reg <= 1'b0;
         arready_reg <= s_axi_arvalid && !rvalid_reg && !arready_reg;
         if (rd_en) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rdata_next;
         end else if (s_axi_rready) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ap_start_reg <= 1'b0;
         ap_done_reg  <= 1'b0;
         gie_reg      <= 1'b0;
         ier_reg      <= 1'b0;
         isr_reg      <= 1'b0;
      end else begin
         // Start is only accepted while idle; writing 0 never aborts a run
         if (hs_complete)                                    ap_start_reg <= 1'b0;
         else if (wr_b0 && s_axi_awaddr == A_CTRL && wbit && hs_idle) ap_start_reg <= 1'b1;
         // Completion beats a concurrent clear-on-read of CTRL
         if (hs_complete)                           ap_done_reg <= 1'b1;
         else if (rd_en && s_axi_araddr == A_CTRL)  ap_done_reg <= 1'b0;
         if (wr_b0 && s_axi_awaddr == A_GIE) gie_reg <= wbit;
         if (wr_b0 && s_axi_awaddr == A_IER) ier_reg <= wbit;
         if (hs_complete && ier_reg)                     isr_reg <= 1'b1;
         else if (wr_b0 && s_axi_awaddr == A_ISR && wbit) isr_reg <= ~isr_reg;
      end
   end

   sda_kernel_handshake u_handshake (
      .clk      (clk),
      .rst_n    (rst_n),
      .ap_start (ap_start_reg),
      .go_0a    (go_0a),
      .done_0r  (done_0r),
      .go_0r    (go_0r),
      .done_0a  (done_0a),
      .idle     (hs_idle),
      .complete (hs_complete),
      .cycles   (hs_cycles)
   );

   assign s_axi_awready = awready_reg;
   assign s_axi_wready  = awready_reg;
   assign s_axi_bvalid  = bvalid_reg;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = arready_reg;
   assign s_axi_rvalid  = rvalid_reg;
   assign s_axi_rdata   = rdata_reg;
   assign s_axi_rresp   = 2'b00;
   assign interrupt     = gie_reg && isr_reg;

endmodule

// File: tb/tb_sda_kernel_ctrl.sv
// Scoreboard bench for sda_kernel_ctrl: stimulus queues expected AXI responses,
// a monitor pops and compares them when the DUT completes each handshake.
module tb_sda_kernel_ctrl;
   localparam int ADDR_W = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [31:0]       wdata, rdata;
   logic [3:0]        wstrb;
   logic [1:0]        bresp, rresp;
   logic              go_0r, go_0a, done_0r, done_0a, interrupt;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] exp_rdata_q[$];
   logic [1:0]  exp_bresp_q[$];

   sda_kernel_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
      .interrupt(interrupt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", name, act);
      end
   endtask

   // Monitor: compares each completed read/write response against the scoreboard
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rvalid && rready) begin
            if (exp_rdata_q.size() == 0) begin
               check("read_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_rdata_q.pop_front();
               check("rdata", rdata, e);
               check("rresp", {30'd0, rresp}, 32'd0);
            end
         end
         if (bvalid && bready) begin
            if (exp_bresp_q.size() == 0) check("write_unexpected", 32'd1, 32'd0);
            else check("bresp", {30'd0, bresp}, {30'd0, exp_bresp_q.pop_front()});
         end
      end
   end

   task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int guard;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      exp_bresp_q.push_back(2'b00);
      guard = 0;
      while (!awready && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (!awready) check("awready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input int hold);
      int guard;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1; rready = 1'b0;
      exp_rdata_q.push_back(exp);
      guard = 0;
      while (!arready && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (!arready) check("arready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rvalid_hold", {31'd0, rvalid}, 32'd1);
         check("rdata_hold", rdata, exp);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic wait_go();
      int guard;
      guard = 0;
      while (!go_0r && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("go_0r_rise", {31'd0, go_0r}, 32'd1);
   endtask

   // Downstream action: ack go immediately, hold done_0r low for 'hold' cycles
   task automatic run_action(input int hold);
      int guard;
      wait_go();
      go_0a = 1'b1;
      repeat (hold) @(negedge clk);
      done_0r = 1'b1;
      guard = 0;
      while (!done_0a && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("done_0a_rise", {31'd0, done_0a}, 32'd1);
      go_0a = 1'b0; done_0r = 1'b0;
      @(negedge clk);
      check("done_0a_fall", {31'd0, done_0a}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int go_cnt;
      reset = 1'b0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      go_0a = 1'b0; done_0r = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {24'd0, go_0r, done_0a, awready, wready, bvalid, arready, rvalid, interrupt}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      axi_read(6'h00, 32'h4, 0);
      axi_read(6'h10, 32'd0, 0);

      // Go and done acked together: GO one cycle, WAIT one cycle, then ACK
      axi_write(6'h00, 32'h1, 4'hF);
      wait_go();
      go_0a = 1'b1; done_0r = 1'b1;
      @(negedge clk);
      check("go_0r_one_cycle", {31'd0, go_0r}, 32'd0);
      @(negedge clk);
      check("done_0a_ack", {31'd0, done_0a}, 32'd1);
      @(negedge clk);
      check("done_0a_held", {31'd0, done_0a}, 32'd1);
      go_0a = 1'b0; done_0r = 1'b0;
      @(negedge clk);
      check("done_0a_drop", {31'd0, done_0a}, 32'd0);
      axi_read(6'h00, 32'h6, 0);
      axi_read(6'h00, 32'h4, 0);
      axi_read(6'h10, 32'd4, 0);

      // Interrupt path
      axi_write(6'h04, 32'h1, 4'hF);
      axi_write(6'h08, 32'h1, 4'hF);
      axi_write(6'h00, 32'h1, 4'hF);
      run_action(0);
      check("irq_set", {31'd0, interrupt}, 32'd1);
      axi_read(6'h0C, 32'h1, 0);
      axi_write(6'h0C, 32'h1, 4'hF);
      check("irq_cleared", {31'd0, interrupt}, 32'd0);
      axi_read(6'h0C, 32'h0, 0);
      axi_read(6'h00, 32'h6, 0);

      // 100-cycle action: 1 GO + 100 WAIT... + ACK edge = hold + 2 counts
      axi_write(6'h00, 32'h1, 4'hF);
      run_action(100);
      axi_read(6'h10, 32'd102, 0);
      repeat (10) @(negedge clk);
      axi_read(6'h10, 32'd102, 0);
      axi_read(6'h00, 32'h6, 0);

      // Start written mid-run must not launch a second go
      axi_write(6'h00, 32'h1, 4'hF);
      wait_go();
      go_0a = 1'b1;
      repeat (3) @(negedge clk);
      axi_write(6'h00, 32'h1, 4'hF);
      axi_read(6'h00, 32'h1, 0);
      done_0r = 1'b1;
      repeat (2) @(negedge clk);
      check("done_0a_mid", {31'd0, done_0a}, 32'd1);
      go_0a = 1'b0; done_0r = 1'b0;
      go_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (go_0r) go_cnt++;
      end
      check("no_second_go", go_cnt, 32'd0);
      axi_read(6'h00, 32'h6, 0);

      // Unmapped accesses and held-off read data
      axi_read(6'h14, 32'd0, 5);
      axi_write(6'h18, 32'hFFFF_FFFF, 4'hF);
      axi_read(6'h04, 32'h1, 0);
      axi_read(6'h08, 32'h1, 0);
      axi_read(6'h0C, 32'h1, 0);
      axi_read(6'h00, 32'h4, 5);

      // Byte strobes
      axi_write(6'h04, 32'h0, 4'h0);
      axi_read(6'h04, 32'h1, 0);
      axi_write(6'h04, 32'h0, 4'h1);
      axi_read(6'h04, 32'h0, 0);
      check("irq_gie_off", {31'd0, interrupt}, 32'd0);
      axi_write(6'h04, 32'h1, 4'h1);

      // Reset in GO drops go_0r without waiting for a clock
      axi_write(6'h00, 32'h1, 4'hF);
      wait_go();
      #2 reset = 1'b0;
      #1;
      check("rst_async_go", {30'd0, go_0r, done_0a}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      axi_read(6'h00, 32'h4, 0);
      axi_read(6'h04, 32'h0, 0);
      axi_read(6'h0C, 32'h0, 0);
      axi_read(6'h10, 32'd0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drain", exp_rdata_q.size() + exp_bresp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
